aes_decrypt_iter: RTL and testbench
===================================

// Module: aes_decrypt_iter
// PURPOSE
//  Iterative AES inverse cipher (FIPS-197 Sec 5.3). It processes one round per clock and is the decrypt-side partner of the round-iterative encrypt path.
//  It accepts a 128-bit ciphertext plus the expanded key schedule over a valid/ready handshake.
//  It returns the plaintext over a second valid/ready handshake.
//  It sits between KeyExpansion and the result/display logic of the AES top level.
// PARAMETERS
//  Nk  4   key length in 32-bit words (4/6/8)
//  Nr  10  number of rounds; must equal Nk+6 (10/12/14)
// PORTS
//  clk         in   1             rising-edge clock
//  rst_n       in   1             asynchronous, active-low reset
//  inValid     in   1             cipherText/allKeys valid
//  inReady     out  1             core can accept a block
//  cipherText  in   128           block to decrypt; byte0 = [127:120], column-major
//  allKeys     in   (Nr+1)*128    round keys; key i = allKeys[(Nr+1-i)*128-1 -: 128], key0 at MSB
//  outValid    out  1             plainText valid
//  outReady    in   1             consumer accepts plainText
//  plainText   out  128           decrypted block, same byte order
//  busy        out  1             high from accept until output handshake completes
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, round=0, state reg=0, plainText=0, outValid=0, busy=0, inReady=0 while rst_n=0.
//  FSM states:
//   IDLE: inReady=1. On inValid&inReady, load st <= cipherText ^ key[Nr], round <= Nr-1, go to RUN.
//   RUN: each cycle st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ key[round]) and round decrements.
//        When round==1 on a cycle, go to LAST.
//   LAST: st <= InvSubBytes(InvShiftRows(st)) ^ key[0]. Assert outValid and register plainText. Go to DONE.
//   DONE: hold plainText/outValid stable. On outReady go to IDLE with outValid=0 next cycle.
//  Latency: the accept edge is cycle 0. outValid rises after edge Nr (Nr=10: edge 10). No round is skipped or merged.
//  Throughput: at most one block per Nr+2 cycles. inReady is high only in IDLE, never in DONE.
//  inValid while busy: ignored, no state change. cipherText is sampled only on the accept edge.
//  outReady low indefinitely: stay in DONE, outputs frozen, no new accept.
//  outReady high before outValid: no effect.
//  Round counter: 4 bits, Nr-1 down to 1. No wrap; the counter is never decremented below 0.
//  Reset mid-operation: immediate abort. The partial block is discarded and outputs return to reset values.
//  S-box: inverse S-box is combinational (16 parallel instances). InvMixColumns uses GF(2^8) xtime chains with modulus 0x11b.
//  busy = (state != IDLE).
// CONFIGURATION
//  AES_DEC_KEYLATCH_EN defined:
//   - allKeys is copied into an internal (Nr+1)*128 register on the accept edge.
//   - Rounds use the copy, so the caller may change allKeys once inReady falls.
//  Undefined:
//   - No key register; rounds read allKeys directly.
//   - The caller must hold allKeys stable from accept until outValid.
//   - Changing allKeys mid-operation yields undefined plainText; there is no error flag.
//  Handshake timing and latency are identical in both builds.
// TESTING
//  T1: Nr=10, key 000102..0f, cipherText 69c4e0d86a7b0430d8cdb78070b4c55a -> plainText 00112233445566778899aabbccddeeff, outValid after edge 10.
//  T2: Nk=8/Nr=14, key 000102..1f, cipherText 8ea2b7ca516745bfeafc49904b496089 -> plainText 00112233..ff, outValid after edge 14.
//  T3: outReady=0 for 20 cycles after outValid -> plainText stable, inReady=0, second inValid ignored. Then outReady=1 -> IDLE, second block accepted next cycle.
//  T4: assert rst_n=0 at cycle 5 of T1 -> outValid=0, plainText=0, busy=0 immediately. Rerunning T1 gives the correct result.
//  T5: inValid pulsed during RUN with different cipherText -> result still equals T1 plaintext.
//  T6 (KEYLATCH_EN): corrupt allKeys to all-zero on cycle 2 of T1 -> plainText still 00112233..ff.
//  T6 (no KEYLATCH_EN): the same corruption makes plainText differ from 00112233..ff.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock, outValid rises Nr edges after the accept edge; accepts only in IDLE, holds result until outReady.
// Define AES_DEC_KEYLATCH_EN to capture allKeys on accept so the caller may change it while the block is in flight.
module aes_decrypt_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [127:0]          cipherText,
   input  logic [(Nr+1)*128-1:0] allKeys,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [127:0]          plainText,
   output logic                  busy
);

   if (Nr != Nk + 6) begin : g_cfg_err
      $error("aes_decrypt_iter: Nr must equal Nk+6");
   end

   typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            round_q;
   logic [127:0]          st_q;
   logic [127:0]          rkey;
   logic [127:0]          ark;
   logic [(Nr+1)*128-1:0] keys;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse affine map, then GF(2^8) inverse as b^254 = b^2*b^4*...*b^128 (0 maps to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      logic [7:0] sq;
      logic [7:0] r;
      b  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      sq = b;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int b = 0; b < 16; b++) begin
         o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

`ifdef AES_DEC_KEYLATCH_EN
   logic [(Nr+1)*128-1:0] key_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            key_q <= '0;
      else if (state_q == IDLE && inValid)   key_q <= allKeys;
   end

   assign keys = key_q;
`else
   assign keys = allKeys;
`endif

   // Key i lives at bits [(Nr-i)*128 +: 128]; round_q is 0 in LAST, selecting key 0.
   always_comb begin
      rkey = keys[127:0];
      for (int i = 0; i <= Nr; i++) begin
         if (round_q == 4'(i)) rkey = keys[(Nr-i)*128 +: 128];
      end
   end

   assign ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ rkey;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inValid) state_d = RUN;
         RUN:     if (round_q == 4'd1) state_d = LAST;
         LAST:    state_d = DONE;
         DONE:    if (outReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= '0;
         round_q   <= 4'd0;
         plainText <= '0;
         outValid  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (inValid) begin
                  st_q    <= cipherText ^ allKeys[127:0];
                  round_q <= 4'(Nr - 1);
               end
            end
            RUN: begin
               st_q <= inv_mix_columns(ark);
               if (round_q != 4'd0) round_q <= round_q - 4'd1;
            end
            LAST: begin
               st_q      <= ark;
               plainText <= ark;
               outValid  <= 1'b1;
            end
            DONE: begin
               if (outReady) outValid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign inReady = rst_n & (state_q == IDLE);
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 AES-128 and AES-256 vectors, backpressure, abort, key stability.
module tb_aes_decrypt_iter;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] ALT   = 128'hdeadbeef0123456789abcdeffedcba98;

   logic clk;
   logic rst_n;

   logic          iv10, ir10, ov10, or10, busy10;
   logic [127:0]  ct10, pt10;
   logic [1407:0] keys10;

   logic          iv14, ir14, ov14, or14, busy14;
   logic [127:0]  ct14, pt14;
   logic [1919:0] keys14;

   logic [0:255][7:0] SBOX_T;
   int checks;
   int errors;

   aes_decrypt_iter #(.Nk(4), .Nr(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .inValid(iv10), .inReady(ir10), .cipherText(ct10),
      .allKeys(keys10), .outValid(ov10), .outReady(or10), .plainText(pt10), .busy(busy10));

   aes_decrypt_iter #(.Nk(8), .Nr(14)) dut14 (
      .clk(clk), .rst_n(rst_n), .inValid(iv14), .inReady(ir14), .cipherText(ct14),
      .allKeys(keys14), .outValid(ov14), .outReady(or14), .plainText(pt14), .busy(busy14));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX_T[x];
   endfunction

   task automatic expand_key(input logic [255:0] key, input int nk, output logic [1919:0] ak);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int total;
      total = 4 * (nk + 7);
      rc = 8'h01;
      ak = '0;
      for (int i = 0; i < total; i++) begin
         if (i < nk) begin
            w[i] = key[(nk-1-i)*32 +: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
               t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
         end
         ak = {ak[1887:0], w[i]};
      end
   endtask

   // Presents one block to dut10 and returns at the falling edge after the accept edge.
   task automatic start10(input logic [127:0] ct);
      @(negedge clk);
      ct10 = ct;
      iv10 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv10 = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (ov10 !== 1'b0 || busy10 !== 1'b0 || pt10 !== 128'h0) begin
         errors++; $display("FAIL reset_out ov=%b busy=%b pt=%h want 0 0 0", ov10, busy10, pt10);
      end
      checks++; if (ir10 !== 1'b0 || ir14 !== 1'b0) begin
         errors++; $display("FAIL reset_inready got %b%b want 00", ir10, ir14);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (ir10 !== 1'b1 || ir14 !== 1'b1) begin
         errors++; $display("FAIL release_inready got %b%b want 11", ir10, ir14);
      end
   endtask

   task automatic test_aes128;
      start10(CT128);
      checks++; if (busy10 !== 1'b1 || ir10 !== 1'b0) begin
         errors++; $display("FAIL t1_busy busy=%b inReady=%b want 1 0", busy10, ir10);
      end
      repeat (9) @(negedge clk);
      checks++; if (ov10 !== 1'b0) begin
         errors++; $display("FAIL t1_early got outValid=%b after edge 9 want 0", ov10);
      end
      @(negedge clk);
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t1_result ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
      @(negedge clk);
      checks++; if (ov10 !== 1'b0 || ir10 !== 1'b1 || busy10 !== 1'b0) begin
         errors++; $display("FAIL t1_handshake ov=%b ir=%b busy=%b want 0 1 0", ov10, ir10, busy10);
      end
   endtask

   task automatic test_aes256;
      @(negedge clk);
      ct14 = CT256;
      iv14 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv14 = 1'b0;
      repeat (13) @(negedge clk);
      checks++; if (ov14 !== 1'b0) begin
         errors++; $display("FAIL t2_early got outValid=%b after edge 13 want 0", ov14);
      end
      @(negedge clk);
      checks++; if (ov14 !== 1'b1 || pt14 !== PT) begin
         errors++; $display("FAIL t2_result ov=%b pt=%h want 1 %h", ov14, pt14, PT);
      end
      @(negedge clk);
      checks++; if (ov14 !== 1'b0 || ir14 !== 1'b1) begin
         errors++; $display("FAIL t2_handshake ov=%b ir=%b want 0 1", ov14, ir14);
      end
   endtask

   task automatic test_backpressure;
      int bad;
      bad = 0;
      or10 = 1'b0;
      start10(CT128);
      repeat (10) @(negedge clk);
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t3_result ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
      iv10 = 1'b1;
      ct10 = ALT;
      repeat (20) begin
         @(negedge clk);
         if (ov10 !== 1'b1 || pt10 !== PT || ir10 !== 1'b0 || busy10 !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin
         errors++; $display("FAIL t3_hold got %0d unstable cycles want 0", bad);
      end
      or10 = 1'b1;
      ct10 = CT128;
      @(negedge clk);
      checks++; if (ov10 !== 1'b0 || ir10 !== 1'b1) begin
         errors++; $display("FAIL t3_release ov=%b ir=%b want 0 1", ov10, ir10);
      end
      @(negedge clk);
      iv10 = 1'b0;
      checks++; if (busy10 !== 1'b1) begin
         errors++; $display("FAIL t3_second_accept busy=%b want 1", busy10);
      end
      repeat (9) @(negedge clk);
      checks++; if (ov10 !== 1'b0) begin
         errors++; $display("FAIL t3_second_early ov=%b want 0", ov10);
      end
      @(negedge clk);
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t3_second_result ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      start10(CT128);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (ov10 !== 1'b0 || pt10 !== 128'h0 || busy10 !== 1'b0 || ir10 !== 1'b0) begin
         errors++; $display("FAIL t4_abort ov=%b pt=%h busy=%b ir=%b want 0 0 0 0", ov10, pt10, busy10, ir10);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start10(CT128);
      repeat (10) @(negedge clk);
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t4_rerun ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
      @(negedge clk);
   endtask

   task automatic test_invalid_while_busy;
      int bad;
      bad = 0;
      start10(CT128);
      repeat (2) @(negedge clk);
      iv10 = 1'b1;
      ct10 = ALT;
      repeat (3) begin
         @(negedge clk);
         if (ir10 !== 1'b0) bad++;
      end
      iv10 = 1'b0;
      checks++; if (bad != 0) begin
         errors++; $display("FAIL t5_inready got %0d ready cycles while busy want 0", bad);
      end
      repeat (4) @(negedge clk);
      checks++; if (ov10 !== 1'b0) begin
         errors++; $display("FAIL t5_early ov=%b want 0", ov10);
      end
      @(negedge clk);
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t5_result ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
      @(negedge clk);
   endtask

   task automatic test_key_change;
      logic [1407:0] saved;
      saved = keys10;
      start10(CT128);
      repeat (2) @(negedge clk);
      keys10 = '0;
      repeat (8) @(negedge clk);
`ifdef AES_DEC_KEYLATCH_EN
      checks++; if (ov10 !== 1'b1 || pt10 !== PT) begin
         errors++; $display("FAIL t6_latched ov=%b pt=%h want 1 %h", ov10, pt10, PT);
      end
`else
      checks++; if (ov10 !== 1'b1 || pt10 === PT) begin
         errors++; $display("FAIL t6_unlatched ov=%b pt=%h want 1 and pt differing from %h", ov10, pt10, PT);
      end
`endif
      keys10 = saved;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1919:0] ak;
      SBOX_T = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      iv10 = 1'b0; or10 = 1'b1; ct10 = '0;
      iv14 = 1'b0; or14 = 1'b1; ct14 = '0;
      expand_key({128'h0, 128'h000102030405060708090a0b0c0d0e0f}, 4, ak);
      keys10 = ak[1407:0];
      expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, ak);
      keys14 = ak;

      test_reset();
      test_aes128();
      test_aes256();
      test_backpressure();
      test_abort();
      test_invalid_while_busy();
      test_key_change();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
